// File: rtl/ehl_fifo_warb_if.sv
// rtl/ehl_fifo_warb_if.sv - requester and FIFO write-port bus of the ehl FIFO write arbiter
// slave is the arbiter side; master is the requester/FIFO side that drives it.
interface ehl_fifo_warb_if #(
  parameter int REQ_CNT      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BURST_MAX    = 4,
  parameter int CREDIT_WIDTH = 4
);
  localparam int LEN_W = $clog2(BURST_MAX + 1);
  localparam int OWN_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  logic [REQ_CNT-1:0]            req;
  logic [REQ_CNT*LEN_W-1:0]      req_len;
  logic [REQ_CNT-1:0]            req_vld;
  logic [REQ_CNT*DATA_WIDTH-1:0] req_data;
  logic [REQ_CNT-1:0]            gnt;
  logic [REQ_CNT-1:0]            ack;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic                          fifo_full;
  logic [CREDIT_WIDTH-1:0]       write_credit;
  logic [OWN_W-1:0]              owner;
  logic                          busy;
  logic                          err;
  logic                          clr_err;

  modport slave (
    input  req, req_len, req_vld, req_data, fifo_full, write_credit, clr_err,
    output gnt, ack, fifo_wr, fifo_wdata, owner, busy, err
  );

  modport master (
    output req, req_len, req_vld, req_data, fifo_full, write_credit, clr_err,
    input  gnt, ack, fifo_wr, fifo_wdata, owner, busy, err
  );
endinterface

// File: rtl/ehl_fifo_warb.sv
// rtl/ehl_fifo_warb.sv - round-robin burst arbiter sharing one ehl FIFO write port
// A burst is granted only when write_credit covers its full length.
module ehl_fifo_warb #(
  parameter int REQ_CNT      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BURST_MAX    = 4,
  parameter int CREDIT_WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  ehl_fifo_warb_if.slave bus
);
  localparam int LEN_W = $clog2(BURST_MAX + 1);
  localparam int OWN_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q;
  logic [REQ_CNT-1:0] gnt_q;
  logic [OWN_W-1:0]   owner_q;
  logic [OWN_W-1:0]   rr_q;
  logic [LEN_W-1:0]   beats_q;
  logic               err_q;

  logic [LEN_W-1:0]      len_a  [REQ_CNT];
  logic [DATA_WIDTH-1:0] data_a [REQ_CNT];
  logic [REQ_CNT-1:0]    legal;
  logic [REQ_CNT-1:0]    cand;
  logic                  bad_req;

  for (genvar i = 0; i < REQ_CNT; i++) begin : g_unpack
    assign len_a[i]  = bus.req_len[i*LEN_W +: LEN_W];
    assign data_a[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign legal[i]  = (len_a[i] != '0) && (len_a[i] <= LEN_W'(BURST_MAX));
  end

  assign cand    = bus.req & legal;
  assign bad_req = |(bus.req & ~legal);

  logic             found;
  logic [OWN_W-1:0] win;
  int               idx;

  // First candidate at or above the rr pointer, wrapping modulo REQ_CNT.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < REQ_CNT; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= REQ_CNT) idx = idx - REQ_CNT;
      if (!found && cand[OWN_W'(idx)]) begin
        found = 1'b1;
        win   = OWN_W'(idx);
      end
    end
  end

  logic             grant_ok;
  logic             busy_w;
  logic [REQ_CNT-1:0] ack_w;
  logic             beat_ok;
  logic             stall_err;
  logic             end_burst;
  logic [OWN_W-1:0] rr_next;

  // No skipping past a winner that lacks credit: it blocks until credit arrives.
  assign grant_ok = found && (32'(bus.write_credit) >= 32'(len_a[win]));
  assign busy_w   = (state_q == BURST);

  always_comb begin
    ack_w = '0;
    if (busy_w && reset_n && bus.req_vld[owner_q] && !bus.fifo_full)
      ack_w[owner_q] = 1'b1;
  end

  assign beat_ok   = |ack_w;
  assign stall_err = busy_w && bus.req_vld[owner_q] && bus.fifo_full;
  assign end_burst = busy_w && (beat_ok ? (beats_q == LEN_W'(1)) : !bus.req[owner_q]);
  assign rr_next   = (owner_q == OWN_W'(REQ_CNT - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (bus.clr_err)
        err_q <= 1'b0;
      else if (bad_req || stall_err)
        err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (grant_ok) begin
            state_q <= BURST;
            gnt_q   <= REQ_CNT'(1) << win;
            owner_q <= win;
            beats_q <= len_a[win];
          end
        end
        BURST: begin
          if (end_burst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            beats_q <= '0;
            rr_q    <= rr_next;
          end else if (beat_ok) begin
            beats_q <= beats_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.ack        = ack_w;
  assign bus.fifo_wr    = beat_ok;
  assign bus.fifo_wdata = busy_w ? data_a[owner_q] : '0;
  assign bus.owner      = owner_q;
  assign bus.busy       = busy_w;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_ehl_fifo_warb.sv
// tb/tb_ehl_fifo_warb.sv - scoreboard bench for the ehl FIFO write arbiter
// Write data encodes {requester, per-requester beat sequence}, so the queue also checks grant order.
module tb_ehl_fifo_warb;
  localparam int REQ_CNT      = 4;
  localparam int DATA_WIDTH   = 8;
  localparam int BURST_MAX    = 4;
  localparam int CREDIT_WIDTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ehl_fifo_warb_if #(
    .REQ_CNT(REQ_CNT), .DATA_WIDTH(DATA_WIDTH),
    .BURST_MAX(BURST_MAX), .CREDIT_WIDTH(CREDIT_WIDTH)
  ) bus ();

  ehl_fifo_warb #(
    .REQ_CNT(REQ_CNT), .DATA_WIDTH(DATA_WIDTH),
    .BURST_MAX(BURST_MAX), .CREDIT_WIDTH(CREDIT_WIDTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic [2:0] len_a   [4];
  logic [3:0] seq_q   [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] exp_seq [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [7:0] sb_q [$];
  logic [3:0] rr_exp [8] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int w0;

  assign bus.req_len  = {len_a[3], len_a[2], len_a[1], len_a[0]};
  assign bus.req_data = {4'd3, seq_q[3], 4'd2, seq_q[2], 4'd1, seq_q[1], 4'd0, seq_q[0]};

  // Each requester moves to its next data word once a beat is acknowledged.
  always @(posedge clk)
    for (int i = 0; i < 4; i++) seq_q[i] <= seq_q[i] + 4'(bus.ack[i]);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] r, input int n);
    for (int b = 0; b < n; b++) begin
      sb_q.push_back({4'(r), exp_seq[r]});
      exp_seq[r] = exp_seq[r] + 4'd1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (bus.fifo_wr === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      if (sb_q.size() == 0)
        check_val("wr_unexpected", 32'd1, 32'd0);
      else
        check_val("wdata", 32'(bus.fifo_wdata), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    bus.req          = '0;
    bus.req_vld      = '0;
    bus.fifo_full    = 1'b0;
    bus.write_credit = '0;
    bus.clr_err      = 1'b0;
    for (int i = 0; i < 4; i++) len_a[i] = 3'd1;
    tick();
    tick();
    check_val("rst_gnt", 32'(bus.gnt), 32'd0);
    check_val("rst_owner", 32'(bus.owner), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);
    check_val("rst_wr", 32'(bus.fifo_wr), 32'd0);
    check_val("rst_wdata", 32'(bus.fifo_wdata), 32'd0);
    reset_n = 1'b1;

    len_a[1] = 3'd3;
    bus.write_credit = 4'd8;
    bus.req = 4'b0010;
    bus.req_vld = 4'b0010;
    push(2'd1, 3);
    tick();
    check_val("single_gnt", 32'(bus.gnt), 32'h2);
    check_val("single_owner", 32'(bus.owner), 32'd1);
    check_val("single_busy", 32'(bus.busy), 32'd1);
    tick();
    tick();
    tick();
    check_val("single_end_gnt", 32'(bus.gnt), 32'd0);
    check_val("single_end_owner", 32'(bus.owner), 32'd0);
    check_val("single_end_busy", 32'(bus.busy), 32'd0);
    check_val("single_wdata_idle", 32'(bus.fifo_wdata), 32'd0);
    check_val("single_wr_cnt", 32'(wr_cnt), 32'd3);
    bus.req = '0;
    bus.req_vld = '0;

    do_reset();
    for (int i = 0; i < 4; i++) len_a[i] = 3'd1;
    bus.write_credit = 4'd15;
    bus.req = 4'b1011;
    bus.req_vld = 4'b1111;
    push(2'd0, 1);
    push(2'd1, 1);
    push(2'd3, 1);
    push(2'd0, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val($sformatf("rr_gnt%0d", k), 32'(bus.gnt), 32'(rr_exp[k]));
    end
    bus.req = '0;
    bus.req_vld = '0;

    do_reset();
    w0 = wr_cnt;
    len_a[0] = 3'd4;
    len_a[1] = 3'd1;
    bus.write_credit = 4'd3;
    bus.req = 4'b0011;
    bus.req_vld = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("credit_hold", 32'(bus.gnt), 32'd0);
    end
    bus.write_credit = 4'd4;
    push(2'd0, 4);
    tick();
    check_val("credit_gnt0", 32'(bus.gnt), 32'h1);
    for (int k = 0; k < 4; k++) tick();
    check_val("credit_idle", 32'(bus.gnt), 32'd0);
    push(2'd1, 1);
    tick();
    check_val("credit_gnt1", 32'(bus.gnt), 32'h2);
    tick();
    bus.req = '0;
    bus.req_vld = '0;
    check_val("credit_wr_cnt", 32'(wr_cnt - w0), 32'd5);

    w0 = wr_cnt;
    len_a[0] = 3'd4;
    bus.write_credit = 4'd8;
    bus.req = 4'b0001;
    push(2'd0, 4);
    tick();
    check_val("stall_gnt", 32'(bus.gnt), 32'h1);
    bus.req_vld = 4'b0001;
    tick();
    bus.req_vld = 4'b0000;
    tick();
    bus.req_vld = 4'b0001;
    tick();
    tick();
    check_val("stall_busy_mid", 32'(bus.busy), 32'd1);
    tick();
    check_val("stall_end_gnt", 32'(bus.gnt), 32'd0);
    check_val("stall_wr_cnt", 32'(wr_cnt - w0), 32'd4);
    bus.req = '0;
    bus.req_vld = '0;

    len_a[2] = 3'd4;
    bus.req = 4'b0100;
    bus.req_vld = 4'b0100;
    push(2'd2, 2);
    tick();
    check_val("abort_gnt", 32'(bus.gnt), 32'h4);
    tick();
    tick();
    bus.req = '0;
    bus.req_vld = '0;
    tick();
    check_val("abort_gnt_off", 32'(bus.gnt), 32'd0);
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_err", 32'(bus.err), 32'd0);
    len_a[0] = 3'd1;
    len_a[2] = 3'd1;
    bus.req = 4'b0101;
    bus.req_vld = 4'b0101;
    push(2'd0, 1);
    push(2'd2, 1);
    tick();
    check_val("abort_ptr_gnt", 32'(bus.gnt), 32'h1);
    tick();
    tick();
    check_val("abort_next_gnt", 32'(bus.gnt), 32'h4);
    tick();
    bus.req = '0;
    bus.req_vld = '0;

    len_a[2] = 3'd0;
    bus.req = 4'b0100;
    tick();
    check_val("err_len0", 32'(bus.err), 32'd1);
    check_val("err_nogrant", 32'(bus.gnt), 32'd0);
    tick();
    check_val("err_nogrant2", 32'(bus.gnt), 32'd0);
    bus.clr_err = 1'b1;
    tick();
    check_val("clr_prio", 32'(bus.err), 32'd0);
    bus.clr_err = 1'b0;
    bus.req = '0;
    len_a[2] = 3'd1;
    tick();
    check_val("clr_hold", 32'(bus.err), 32'd0);

    w0 = wr_cnt;
    len_a[3] = 3'd2;
    bus.req = 4'b1000;
    bus.req_vld = 4'b1000;
    push(2'd3, 2);
    tick();
    check_val("full_gnt", 32'(bus.gnt), 32'h8);
    bus.fifo_full = 1'b1;
    tick();
    check_val("full_err", 32'(bus.err), 32'd1);
    check_val("full_busy", 32'(bus.busy), 32'd1);
    check_val("full_no_wr", 32'(wr_cnt - w0), 32'd0);
    bus.fifo_full = 1'b0;
    tick();
    tick();
    check_val("full_end_gnt", 32'(bus.gnt), 32'd0);
    check_val("full_wr_cnt", 32'(wr_cnt - w0), 32'd2);
    bus.req = '0;
    bus.req_vld = '0;

    w0 = wr_cnt;
    len_a[0] = 3'd4;
    bus.req = 4'b0001;
    bus.req_vld = 4'b0001;
    push(2'd0, 1);
    tick();
    check_val("rstmid_gnt", 32'(bus.gnt), 32'h1);
    tick();
    reset_n = 1'b0;
    tick();
    check_val("rstmid_gnt_off", 32'(bus.gnt), 32'd0);
    check_val("rstmid_busy", 32'(bus.busy), 32'd0);
    check_val("rstmid_err", 32'(bus.err), 32'd0);
    check_val("rstmid_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    reset_n = 1'b1;
    push(2'd0, 4);
    tick();
    check_val("rstmid_regnt", 32'(bus.gnt), 32'h1);
    for (int k = 0; k < 4; k++) tick();
    check_val("rstmid_end_gnt", 32'(bus.gnt), 32'd0);
    check_val("rstmid_full_len", 32'(wr_cnt - w0), 32'd5);
    bus.req = '0;
    bus.req_vld = '0;

    tick();
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
